servisia_mem_scoreboard: RTL and testbench
==========================================

SERVISIA_MEM_SCOREBOARD -- requirements
Module: servisia_mem_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: shadow-memory address width; depth is 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: word width.
REQ-003 SHALL have parameter RD_LATENCY, default 1: cycles from ren_i to valid rdata_i; legal range 1..4.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of all counters.
REQ-005 SHALL have parameter MAX_ERRORS, default 0: error count that asserts halt_o; 0 disables halt.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port clear_i, input, 1: clears counters, status and capture registers, but not shadow contents.
REQ-009 SHALL have ports wen_i (1), waddr_i (ADDR_WIDTH), wdata_i (DATA_WIDTH), all inputs: DUT write snoop.
REQ-010 SHALL have ports ren_i (1) and raddr_i (ADDR_WIDTH), both inputs: DUT read request snoop.
REQ-011 SHALL have port rdata_i, input, DATA_WIDTH: DUT read data.
REQ-012 SHALL have port mismatch_o, output, 1: one-cycle mismatch pulse.
REQ-013 SHALL have port error_o, output, 1: sticky error flag.
REQ-014 SHALL have ports err_cnt_o, chk_cnt_o and skip_cnt_o, outputs, CNT_WIDTH each: mismatch, compared-read and skipped-read counts.
REQ-015 SHALL have ports first_addr_o, first_exp_o and first_act_o, outputs, ADDR/DATA/DATA_WIDTH: first-mismatch capture.
REQ-016 SHALL have ports last_addr_o, last_exp_o and last_act_o, outputs, ADDR/DATA/DATA_WIDTH: last-mismatch capture.
REQ-017 SHALL have port halt_o, output, 1: sticky halt request.

Function
REQ-018 SHALL hold a shadow array of 2^ADDR_WIDTH words and a per-entry written bit.
REQ-019 SHALL, on wen_i, store wdata_i at waddr_i and set that entry's written bit in the same edge.
REQ-020 SHALL, on ren_i, sample the expected word and written bit at raddr_i and push them into an RD_LATENCY-deep pipeline.
REQ-021 SHALL use read-before-write semantics: wen_i and ren_i to the same address in one cycle yield the old word as expected.
REQ-022 SHALL compare rdata_i against expected exactly RD_LATENCY cycles after ren_i; ren_i may assert every cycle.
REQ-023 SHALL, if the entry was unwritten, skip the compare and increment skip_cnt_o only.
REQ-024 SHALL, on a compare, increment chk_cnt_o; on inequality, pulse mismatch_o for one cycle in the compare cycle, set error_o and increment err_cnt_o.
REQ-025 SHALL capture the first_* registers only on the first mismatch after reset or clear_i.
REQ-026 SHALL saturate every counter at 2^CNT_WIDTH-1 with no wrap-around.
REQ-027 SHALL, when MAX_ERRORS != 0, set halt_o on the edge err_cnt_o reaches MAX_ERRORS; halt_o is sticky until reset or clear_i.
REQ-028 SHALL give clear_i priority over a concurrent compare.
REQ-029 SHALL flush the pipeline on clear_i, so reads in flight are dropped, neither counted nor compared.

Reset
REQ-030 SHALL, while rst_ni=0 at an edge, clear all written bits, pipeline valids, counters and capture registers, and mismatch_o, error_o and halt_o; all outputs read 0 the cycle after.
REQ-031 SHALL leave shadow data contents undefined and unreset; only the written bits define validity.
REQ-032 SHALL, on reset asserted mid-read, discard in-flight reads with no compare.

Configuration
REQ-033 SHALL use macro SERVISIA_MEMCHK_LAST_EN: when defined, last_* update on every mismatch and clear on reset/clear_i.
REQ-034 SHALL, without SERVISIA_MEMCHK_LAST_EN, tie last_* to constant 0 and implement no capture registers.

Verification
REQ-035 Write addr 5=0xA5, read 5 with rdata_i=0xA5 at latency 1 -> chk_cnt_o=1, err_cnt_o=0, mismatch_o never high.
REQ-036 Read unwritten addr 7 with any rdata_i -> skip_cnt_o=1, chk_cnt_o=0, error_o=0.
REQ-037 Addr 3=0x11 and 4=0x22, back-to-back reads with returns 0x11 then 0x99, RD_LATENCY=3 -> one mismatch_o pulse 3 cycles after the second ren_i; first_addr_o=4, first_exp_o=0x22, first_act_o=0x99.
REQ-038 Same-cycle write 0x55 and read of addr 9 (holding 0x44) -> expected 0x44; a return of 0x55 counts as a mismatch.
REQ-039 MAX_ERRORS=2, three mismatches -> halt_o rises with the second mismatch; err_cnt_o=3; clear_i drops halt_o, error_o and counters to 0 while addr 3 still compares as 0x11.
REQ-040 CNT_WIDTH=4, 20 matching reads -> chk_cnt_o holds at 15; with the macro defined, last_* track the latest of two mismatches.

Source files
------------

// File: rtl/servisia_mem_scoreboard.sv
// Shadow-memory read checker: mirrors snooped writes and compares returned read data.
// Optional last-mismatch capture is enabled by defining SERVISIA_MEMCHK_LAST_EN.
module servisia_mem_scoreboard #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_ERRORS = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  ren_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  mismatch_o,
  output logic                  error_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  chk_cnt_o,
  output logic [CNT_WIDTH-1:0]  skip_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_addr_o,
  output logic [DATA_WIDTH-1:0] first_exp_o,
  output logic [DATA_WIDTH-1:0] first_act_o,
  output logic [ADDR_WIDTH-1:0] last_addr_o,
  output logic [DATA_WIDTH-1:0] last_exp_o,
  output logic [DATA_WIDTH-1:0] last_act_o,
  output logic                  halt_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] MAX_ERR_C = CNT_WIDTH'(MAX_ERRORS);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      wr_q;

  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY-1:0] wb_q;
  logic [DATA_WIDTH-1:0] exp_q  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];

  logic                  cmp_vld, cmp_do, cmp_skip, cmp_mm;

  logic [CNT_WIDTH-1:0]  err_q, err_d, chk_q, chk_d, skip_q, skip_d;
  logic                  error_q, error_d, halt_q, halt_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fexp_q, fexp_d, fact_q, fact_d;

  // Shadow data is deliberately unreset; the written bits alone define validity.
  always_ff @(posedge clk_i) begin
    if (wen_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) wr_q <= '0;
    else if (wen_i) wr_q[waddr_i] <= 1'b1;
  end

  // Read pipeline: nonblocking sampling gives read-before-write on same-address collisions.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= ren_i;
      for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    exp_q[0]  <= mem_q[raddr_i];
    wb_q[0]   <= wr_q[raddr_i];
    addr_q[0] <= raddr_i;
    for (int i = 1; i < RD_LATENCY; i++) begin
      exp_q[i]  <= exp_q[i-1];
      wb_q[i]   <= wb_q[i-1];
      addr_q[i] <= addr_q[i-1];
    end
  end

  // Compare stage; clear and reset suppress any compare in progress.
  assign cmp_vld  = vld_q[RD_LATENCY-1] & rst_ni & ~clear_i;
  assign cmp_do   = cmp_vld & wb_q[RD_LATENCY-1];
  assign cmp_skip = cmp_vld & ~wb_q[RD_LATENCY-1];
  assign cmp_mm   = cmp_do & (rdata_i != exp_q[RD_LATENCY-1]);

  always_comb begin
    err_d   = err_q;
    chk_d   = chk_q;
    skip_d  = skip_q;
    error_d = error_q;
    halt_d  = halt_q;
    faddr_d = faddr_q;
    fexp_d  = fexp_q;
    fact_d  = fact_q;
    if (clear_i) begin
      err_d   = '0;
      chk_d   = '0;
      skip_d  = '0;
      error_d = 1'b0;
      halt_d  = 1'b0;
      faddr_d = '0;
      fexp_d  = '0;
      fact_d  = '0;
    end else begin
      if (cmp_do)   chk_d  = sat_inc(chk_q);
      if (cmp_skip) skip_d = sat_inc(skip_q);
      if (cmp_mm) begin
        err_d   = sat_inc(err_q);
        error_d = 1'b1;
        // error_q low means no mismatch has been seen since reset or clear.
        if (!error_q) begin
          faddr_d = addr_q[RD_LATENCY-1];
          fexp_d  = exp_q[RD_LATENCY-1];
          fact_d  = rdata_i;
        end
        if (MAX_ERRORS != 0 && err_d == MAX_ERR_C) halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q   <= '0;
      chk_q   <= '0;
      skip_q  <= '0;
      error_q <= 1'b0;
      halt_q  <= 1'b0;
      faddr_q <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
    end else begin
      err_q   <= err_d;
      chk_q   <= chk_d;
      skip_q  <= skip_d;
      error_q <= error_d;
      halt_q  <= halt_d;
      faddr_q <= faddr_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
    end
  end

`ifdef SERVISIA_MEMCHK_LAST_EN
  logic [ADDR_WIDTH-1:0] laddr_q;
  logic [DATA_WIDTH-1:0] lexp_q, lact_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      laddr_q <= '0;
      lexp_q  <= '0;
      lact_q  <= '0;
    end else if (cmp_mm) begin
      laddr_q <= addr_q[RD_LATENCY-1];
      lexp_q  <= exp_q[RD_LATENCY-1];
      lact_q  <= rdata_i;
    end
  end

  assign last_addr_o = laddr_q;
  assign last_exp_o  = lexp_q;
  assign last_act_o  = lact_q;
`else
  assign last_addr_o = '0;
  assign last_exp_o  = '0;
  assign last_act_o  = '0;
`endif

  assign mismatch_o   = cmp_mm;
  assign error_o      = error_q;
  assign err_cnt_o    = err_q;
  assign chk_cnt_o    = chk_q;
  assign skip_cnt_o   = skip_q;
  assign first_addr_o = faddr_q;
  assign first_exp_o  = fexp_q;
  assign first_act_o  = fact_q;
  assign halt_o       = halt_q;

endmodule

// File: tb/tb_servisia_mem_scoreboard.sv
// Scoreboard bench: two checkers (latency 1 with 4-bit counters and halt at 2,
// latency 3 with 16-bit counters) observe the same memory traffic.
module tb_servisia_mem_scoreboard;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int CW_A = 4;
  localparam int CW_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ni, clear_i, wen_i, ren_i;
  logic [AW-1:0] waddr_i, raddr_i;
  logic [DW-1:0] wdata_i, rdata_a, rdata_b;

  logic mm_a, err_a, halt_a, mm_b, err_b, halt_b;
  logic [CW_A-1:0] ecnt_a, ccnt_a, scnt_a;
  logic [CW_B-1:0] ecnt_b, ccnt_b, scnt_b;
  logic [AW-1:0] fa_a, la_a, fa_b, la_b;
  logic [DW-1:0] fe_a, fx_a, le_a, lx_a, fe_b, fx_b, le_b, lx_b;

  servisia_mem_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT_A),
                            .CNT_WIDTH(CW_A), .MAX_ERRORS(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .ren_i(ren_i), .raddr_i(raddr_i), .rdata_i(rdata_a),
    .mismatch_o(mm_a), .error_o(err_a),
    .err_cnt_o(ecnt_a), .chk_cnt_o(ccnt_a), .skip_cnt_o(scnt_a),
    .first_addr_o(fa_a), .first_exp_o(fe_a), .first_act_o(fx_a),
    .last_addr_o(la_a), .last_exp_o(le_a), .last_act_o(lx_a),
    .halt_o(halt_a));

  servisia_mem_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT_B),
                            .CNT_WIDTH(CW_B), .MAX_ERRORS(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .ren_i(ren_i), .raddr_i(raddr_i), .rdata_i(rdata_b),
    .mismatch_o(mm_b), .error_o(err_b),
    .err_cnt_o(ecnt_b), .chk_cnt_o(ccnt_b), .skip_cnt_o(scnt_b),
    .first_addr_o(fa_b), .first_exp_o(fe_b), .first_act_o(fx_b),
    .last_addr_o(la_b), .last_exp_o(le_b), .last_act_o(lx_b),
    .halt_o(halt_b));

  typedef struct {
    int          due;
    bit          wr;
    logic [DW-1:0] exp;
    logic [DW-1:0] act;
  } rd_t;

  rd_t qa[$];
  rd_t qb[$];
  logic [DW-1:0] mem_m [1<<AW];
  bit            wr_m  [1<<AW];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int mm_bad, mm_cnt_a, mm_cnt_b, mm_cyc_b;

  // One clock cycle of traffic; reads push their expected outcome, due compares pop it.
  task automatic step(input bit wen, input int wa, input logic [DW-1:0] wd,
                      input bit ren, input int ra, input logic [DW-1:0] ret);
    rd_t it;
    bit ea, eb;
    wen_i = wen; waddr_i = AW'(wa); wdata_i = wd;
    ren_i = ren; raddr_i = AW'(ra);
    if (ren) begin
      it.wr = wr_m[ra]; it.exp = mem_m[ra]; it.act = ret;
      it.due = cyc + LAT_A; qa.push_back(it);
      it.due = cyc + LAT_B; qb.push_back(it);
    end
    rdata_a = DW'($urandom); rdata_b = DW'($urandom);
    ea = 1'b0; eb = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      rdata_a = qa[0].act;
      ea = rst_ni && !clear_i && qa[0].wr && (qa[0].act != qa[0].exp);
      void'(qa.pop_front());
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      rdata_b = qb[0].act;
      eb = rst_ni && !clear_i && qb[0].wr && (qb[0].act != qb[0].exp);
      void'(qb.pop_front());
    end
    @(negedge clk);
    if (mm_a !== ea) mm_bad++;
    if (mm_b !== eb) mm_bad++;
    if (mm_a === 1'b1) mm_cnt_a++;
    if (mm_b === 1'b1) begin mm_cnt_b++; mm_cyc_b = cyc; end
    @(posedge clk); #1;
    if (!rst_ni) begin
      qa.delete(); qb.delete();
      foreach (wr_m[i]) wr_m[i] = 1'b0;
    end else begin
      if (clear_i) begin qa.delete(); qb.delete(); end
      if (wen) begin mem_m[wa] = wd; wr_m[wa] = 1'b1; end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00, 0, 0, 8'h00);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    step(1, a, d, 0, 0, 8'h00);
  endtask

  task automatic rd(input int a, input logic [DW-1:0] ret);
    step(0, 0, 8'h00, 1, a, ret);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    mm_bad = 0; mm_cnt_a = 0; mm_cnt_b = 0; mm_cyc_b = -1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({mm_a, err_a, halt_a, ecnt_a, ccnt_a, scnt_a, fa_a, fe_a, fx_a, la_a, le_a, lx_a} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_a: got nonzero, want all 0");
    end
    n_cmp++;
    if ({mm_b, err_b, halt_b, ecnt_b, ccnt_b, scnt_b, fa_b, fe_b, fx_b, la_b, le_b, lx_b} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_b: got nonzero, want all 0");
    end
    wr(5, 8'hA5);
    rd(5, 8'h00);
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    idle(5);
    n_cmp++;
    if ({ecnt_a, ccnt_a, scnt_a, ecnt_b, ccnt_b, scnt_b, err_a, err_b} !== '0) begin
      n_fail++; $display("FAIL reset_inflight_counts: got nonzero, want 0");
    end
    n_cmp++;
    if (mm_cnt_a + mm_cnt_b !== 0 || mm_bad !== 0) begin
      n_fail++; $display("FAIL reset_inflight_pulses: got %0d pulses/%0d bad, want 0/0", mm_cnt_a + mm_cnt_b, mm_bad);
    end
  endtask

  task automatic test_match();
    do_reset();
    wr(5, 8'hA5);
    rd(5, 8'hA5);
    idle(4);
    n_cmp++;
    if (ccnt_a !== 4'd1 || ecnt_a !== 4'd0 || mm_cnt_a !== 0) begin
      n_fail++; $display("FAIL match_a: got chk=%0d err=%0d pulses=%0d, want 1 0 0", ccnt_a, ecnt_a, mm_cnt_a);
    end
    n_cmp++;
    if (ccnt_b !== 16'd1 || ecnt_b !== 16'd0 || mm_cnt_b !== 0 || mm_bad !== 0) begin
      n_fail++; $display("FAIL match_b: got chk=%0d err=%0d pulses=%0d bad=%0d, want 1 0 0 0", ccnt_b, ecnt_b, mm_cnt_b, mm_bad);
    end
  endtask

  task automatic test_unwritten();
    do_reset();
    rd(7, 8'h3C);
    idle(4);
    n_cmp++;
    if (scnt_a !== 4'd1 || ccnt_a !== 4'd0 || err_a !== 1'b0) begin
      n_fail++; $display("FAIL unwritten_a: got skip=%0d chk=%0d err=%0b, want 1 0 0", scnt_a, ccnt_a, err_a);
    end
    n_cmp++;
    if (scnt_b !== 16'd1 || ccnt_b !== 16'd0 || err_b !== 1'b0 || mm_bad !== 0) begin
      n_fail++; $display("FAIL unwritten_b: got skip=%0d chk=%0d err=%0b bad=%0d, want 1 0 0 0", scnt_b, ccnt_b, err_b, mm_bad);
    end
  endtask

  task automatic test_back_to_back();
    int r2;
    do_reset();
    wr(3, 8'h11);
    wr(4, 8'h22);
    rd(3, 8'h11);
    r2 = cyc;
    rd(4, 8'h99);
    idle(5);
    n_cmp++;
    if (mm_cnt_b !== 1 || mm_cyc_b !== r2 + 3) begin
      n_fail++; $display("FAIL b2b_pulse: got %0d pulses at cycle %0d, want 1 at %0d", mm_cnt_b, mm_cyc_b, r2 + 3);
    end
    n_cmp++;
    if (fa_b !== 10'd4 || fe_b !== 8'h22 || fx_b !== 8'h99) begin
      n_fail++; $display("FAIL b2b_first: got addr=%0d exp=%h act=%h, want 4 22 99", fa_b, fe_b, fx_b);
    end
    n_cmp++;
    if (ccnt_b !== 16'd2 || ecnt_b !== 16'd1 || ecnt_a !== 4'd1 || mm_bad !== 0) begin
      n_fail++; $display("FAIL b2b_counts: got chk_b=%0d err_b=%0d err_a=%0d bad=%0d, want 2 1 1 0", ccnt_b, ecnt_b, ecnt_a, mm_bad);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    wr(9, 8'h44);
    step(1, 9, 8'h55, 1, 9, 8'h55);
    idle(4);
    n_cmp++;
    if (ecnt_a !== 4'd1 || fe_a !== 8'h44 || fx_a !== 8'h55 || fa_a !== 10'd9) begin
      n_fail++; $display("FAIL rbw_a: got err=%0d addr=%0d exp=%h act=%h, want 1 9 44 55", ecnt_a, fa_a, fe_a, fx_a);
    end
    rd(9, 8'h55);
    idle(4);
    n_cmp++;
    if (ecnt_b !== 16'd1 || ccnt_b !== 16'd2 || fe_b !== 8'h44 || mm_bad !== 0) begin
      n_fail++; $display("FAIL rbw_b: got err=%0d chk=%0d exp=%h bad=%0d, want 1 2 44 0", ecnt_b, ccnt_b, fe_b, mm_bad);
    end
  endtask

  task automatic test_halt_clear();
    do_reset();
    wr(3, 8'h11);
    rd(3, 8'h00);
    idle(3);
    n_cmp++;
    if (halt_a !== 1'b0 || ecnt_a !== 4'd1) begin
      n_fail++; $display("FAIL halt_first: got halt=%0b err=%0d, want 0 1", halt_a, ecnt_a);
    end
    rd(3, 8'h00);
    idle(1);
    n_cmp++;
    if (halt_a !== 1'b1 || ecnt_a !== 4'd2) begin
      n_fail++; $display("FAIL halt_second: got halt=%0b err=%0d, want 1 2", halt_a, ecnt_a);
    end
    rd(3, 8'h00);
    idle(4);
    n_cmp++;
    if (halt_a !== 1'b1 || ecnt_a !== 4'd3 || err_a !== 1'b1 || halt_b !== 1'b0 || ecnt_b !== 16'd3) begin
      n_fail++; $display("FAIL halt_third: got halt_a=%0b err_a=%0d halt_b=%0b err_b=%0d, want 1 3 0 3", halt_a, ecnt_a, halt_b, ecnt_b);
    end
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
    n_cmp++;
    if ({halt_a, err_a, ecnt_a, ccnt_a, scnt_a, fa_a, fe_a, fx_a, halt_b, err_b, ecnt_b, ccnt_b} !== '0) begin
      n_fail++; $display("FAIL clear_state: got nonzero, want all 0");
    end
    rd(3, 8'h77);
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
    idle(4);
    n_cmp++;
    if ({ecnt_a, ccnt_a, ecnt_b, ccnt_b, err_a, err_b} !== '0) begin
      n_fail++; $display("FAIL clear_flush: got err_a=%0d chk_a=%0d err_b=%0d chk_b=%0d, want 0", ecnt_a, ccnt_a, ecnt_b, ccnt_b);
    end
    rd(3, 8'h11);
    idle(4);
    n_cmp++;
    if (ccnt_a !== 4'd1 || ecnt_a !== 4'd0 || ccnt_b !== 16'd1 || mm_bad !== 0) begin
      n_fail++; $display("FAIL clear_shadow_kept: got chk_a=%0d err_a=%0d chk_b=%0d bad=%0d, want 1 0 1 0", ccnt_a, ecnt_a, ccnt_b, mm_bad);
    end
  endtask

  task automatic test_saturate_last();
    do_reset();
    wr(5, 8'hA5);
    wr(3, 8'h11);
    for (int i = 0; i < 20; i++) rd(5, 8'hA5);
    idle(4);
    n_cmp++;
    if (ccnt_a !== 4'd15 || ccnt_b !== 16'd20) begin
      n_fail++; $display("FAIL saturate: got chk_a=%0d chk_b=%0d, want 15 20", ccnt_a, ccnt_b);
    end
    rd(5, 8'h01);
    rd(3, 8'h02);
    idle(4);
    n_cmp++;
    if (ecnt_a !== 4'd2 || fa_a !== 10'd5 || fe_a !== 8'hA5 || fx_a !== 8'h01 || mm_bad !== 0) begin
      n_fail++; $display("FAIL two_mm_first: got err=%0d addr=%0d exp=%h act=%h bad=%0d, want 2 5 a5 01 0", ecnt_a, fa_a, fe_a, fx_a, mm_bad);
    end
`ifdef SERVISIA_MEMCHK_LAST_EN
    n_cmp++;
    if (la_a !== 10'd3 || le_a !== 8'h11 || lx_a !== 8'h02 || la_b !== 10'd3 || lx_b !== 8'h02) begin
      n_fail++; $display("FAIL last_track: got addr=%0d exp=%h act=%h, want 3 11 02", la_a, le_a, lx_a);
    end
`else
    n_cmp++;
    if ({la_a, le_a, lx_a, la_b, le_b, lx_b} !== '0) begin
      n_fail++; $display("FAIL last_tied: got addr=%0d exp=%h act=%h, want 0", la_a, le_a, lx_a);
    end
`endif
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0;
    wen_i = 1'b0; waddr_i = '0; wdata_i = '0;
    ren_i = 1'b0; raddr_i = '0; rdata_a = '0; rdata_b = '0;
    mm_bad = 0; mm_cnt_a = 0; mm_cnt_b = 0; mm_cyc_b = -1;
    @(posedge clk); #1;
    test_reset();
    test_match();
    test_unwritten();
    test_back_to_back();
    test_same_cycle();
    test_halt_clear();
    test_saturate_last();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
